// File: rtl/aes_stream_ctrl.sv
// Stream controller around an iterative AES core: key load, block handshake, result hand-off.
// Define AES_STREAM_CBC_EN to build with CBC chaining; the default build is ECB.
module aes_stream_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] cfg_key,
  input  logic         cfg_keylen,
  input  logic         cfg_enc_dec,
  input  logic [127:0] cfg_iv,
  input  logic         cfg_load,
  output logic         cfg_done,
  output logic         key_valid,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic         core_keylen,
  output logic         core_enc_dec,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic         core_result_valid,
  input  logic [127:0] core_result
);

  localparam int unsigned KEY_W = 256;
  localparam int unsigned BLK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEY_INIT = 3'd1,
    ST_KEY_WAIT = 3'd2,
    ST_RDY      = 3'd3,
    ST_START    = 3'd4,
    ST_WAIT     = 3'd5,
    ST_OUT      = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic               first_q, first_d;
  logic               cfg_done_q, cfg_done_d;
  logic               key_valid_q, key_valid_d;
  logic               m_valid_q, m_valid_d;
  logic [BLK_W-1:0]   m_data_q, m_data_d;
  logic               core_init_q, core_init_d;
  logic               core_next_q, core_next_d;
  logic [KEY_W-1:0]   core_key_q, core_key_d;
  logic               core_keylen_q, core_keylen_d;
  logic               core_enc_dec_q, core_enc_dec_d;
  logic [BLK_W-1:0]   core_block_q, core_block_d;
  logic [BLK_W-1:0]   blk_in;
  logic [BLK_W-1:0]   res_out;

`ifdef AES_STREAM_CBC_EN
  logic [BLK_W-1:0]   chain_q, chain_d;

  // Encrypt whitens the plaintext; decrypt unwhitens the core output.
  assign blk_in  = core_enc_dec_q ? (s_data ^ chain_q) : s_data;
  assign res_out = core_enc_dec_q ? core_result : (core_result ^ chain_q);
`else
  logic unused_iv;

  assign unused_iv = ^cfg_iv;
  assign blk_in    = s_data;
  assign res_out   = core_result;
`endif

  // Reload request always wins over a block offered in the same cycle.
  assign s_ready      = (state_q == ST_RDY) && !cfg_load;
  assign cfg_done     = cfg_done_q;
  assign key_valid    = key_valid_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign core_init    = core_init_q;
  assign core_next    = core_next_q;
  assign core_key     = core_key_q;
  assign core_keylen  = core_keylen_q;
  assign core_enc_dec = core_enc_dec_q;
  assign core_block   = core_block_q;

  // Next-state and next-output logic; strobes default low, held values default to current.
  always_comb begin
    state_d        = state_q;
    first_d        = 1'b0;
    cfg_done_d     = 1'b0;
    core_init_d    = 1'b0;
    core_next_d    = 1'b0;
    key_valid_d    = key_valid_q;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    core_key_d     = core_key_q;
    core_keylen_d  = core_keylen_q;
    core_enc_dec_d = core_enc_dec_q;
    core_block_d   = core_block_q;
`ifdef AES_STREAM_CBC_EN
    chain_d        = chain_q;
`endif

    case (state_q)
      ST_IDLE, ST_RDY: begin
        if (cfg_load) begin
          core_key_d     = cfg_key;
          core_keylen_d  = cfg_keylen;
          core_enc_dec_d = cfg_enc_dec;
          key_valid_d    = 1'b0;
          core_init_d    = 1'b1;
          state_d        = ST_KEY_INIT;
`ifdef AES_STREAM_CBC_EN
          chain_d        = cfg_iv;
`endif
        end else if ((state_q == ST_RDY) && s_valid) begin
          core_block_d = blk_in;
          core_next_d  = 1'b1;
          state_d      = ST_START;
        end
      end

      ST_KEY_INIT: begin
        first_d = 1'b1;
        state_d = ST_KEY_WAIT;
      end

      // core_ready may still be stale from before the strobe in the first cycle.
      ST_KEY_WAIT: begin
        if (!first_q && core_ready) begin
          cfg_done_d  = 1'b1;
          key_valid_d = 1'b1;
          state_d     = ST_RDY;
        end
      end

      ST_START: begin
        first_d = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (!first_q && core_ready && core_result_valid) begin
          m_data_d  = res_out;
          m_valid_d = 1'b1;
          state_d   = ST_OUT;
`ifdef AES_STREAM_CBC_EN
          chain_d   = core_enc_dec_q ? core_result : core_block_q;
`endif
        end
      end

      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_RDY;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      first_q        <= 1'b0;
      cfg_done_q     <= 1'b0;
      key_valid_q    <= 1'b0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      core_init_q    <= 1'b0;
      core_next_q    <= 1'b0;
      core_key_q     <= '0;
      core_keylen_q  <= 1'b0;
      core_enc_dec_q <= 1'b0;
      core_block_q   <= '0;
`ifdef AES_STREAM_CBC_EN
      chain_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      first_q        <= first_d;
      cfg_done_q     <= cfg_done_d;
      key_valid_q    <= key_valid_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      core_init_q    <= core_init_d;
      core_next_q    <= core_next_d;
      core_key_q     <= core_key_d;
      core_keylen_q  <= core_keylen_d;
      core_enc_dec_q <= core_enc_dec_d;
      core_block_q   <= core_block_d;
`ifdef AES_STREAM_CBC_EN
      chain_q        <= chain_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Scoreboard bench for aes_stream_ctrl with a lookup-table AES core stand-in.
`timescale 1ns/1ps
module tb_aes_stream_ctrl;

  localparam int unsigned TMO = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] cfg_key;
  logic         cfg_keylen, cfg_enc_dec, cfg_load;
  logic [127:0] cfg_iv;
  logic         cfg_done, key_valid;
  logic         s_valid, s_ready;
  logic [127:0] s_data;
  logic         m_valid, m_ready;
  logic [127:0] m_data;
  logic         core_init, core_next, core_keylen, core_enc_dec;
  logic [255:0] core_key;
  logic [127:0] core_block;
  logic         core_ready, core_result_valid;
  logic [127:0] core_result;

  always #5 clk = ~clk;

  aes_stream_ctrl dut (
    .clk(clk), .reset(reset),
    .cfg_key(cfg_key), .cfg_keylen(cfg_keylen), .cfg_enc_dec(cfg_enc_dec),
    .cfg_iv(cfg_iv), .cfg_load(cfg_load), .cfg_done(cfg_done), .key_valid(key_valid),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .core_init(core_init), .core_next(core_next), .core_key(core_key),
    .core_keylen(core_keylen), .core_enc_dec(core_enc_dec), .core_block(core_block),
    .core_ready(core_ready), .core_result_valid(core_result_valid), .core_result(core_result)
  );

  int errors = 0;
  int checks = 0;
  int n_init = 0, n_next = 0, n_done = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_out = '0;
  logic         enc_m = 1'b1;
  logic [127:0] chain_m = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Known AES answers for the directed vectors; anything else maps to the bitwise inverse.
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic enc, input logic [127:0] b);
    if (enc && k[255:128] == 128'h000102030405060708090a0b0c0d0e0f &&
        b == 128'h00112233445566778899aabbccddeeff)
      return 128'h69c4e0d86e7a0430d8cdb78070b4c55a;
    if (enc && k[255:128] == 128'h2b7e151628aed2a6abf7158809cf4f3c &&
        b == 128'h6bc0bce12a459991e134741a7f9e1925)
      return 128'h7649abac8119b246cee98e9b12e9197d;
    if (!enc && k[255:128] == 128'h2b7e151628aed2a6abf7158809cf4f3c &&
        b == 128'h7649abac8119b246cee98e9b12e9197d)
      return 128'h6bc0bce12a459991e134741a7f9e1925;
    return ~b;
  endfunction

  // Core stand-in: ready stays stale for one cycle after a strobe, then busy for four.
  logic go = 1'b0, was_next = 1'b0;
  int   cnt = 0;
  initial begin
    core_ready = 1'b1;
    core_result_valid = 1'b0;
    core_result = '0;
  end
  always @(posedge clk) begin
    if (go) begin
      core_ready <= 1'b0;
      core_result_valid <= 1'b0;
      cnt <= 4;
      go <= 1'b0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        core_ready <= 1'b1;
        core_result_valid <= was_next;
        if (was_next) core_result <= core_fn(core_key, core_enc_dec, core_block);
      end
    end
    if (core_init || core_next) begin
      go <= 1'b1;
      was_next <= core_next;
    end
  end

  // Monitor: pulse counters, core protocol, scoreboard pop.
  always @(negedge clk) begin
    if (core_init) n_init++;
    if (core_next) n_next++;
    if (cfg_done)  n_done++;
    if (core_init || core_next) check("core_strobe_while_busy", 256'(go || cnt != 0), 256'(0));
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_unexpected: got m_data %h expected no output", m_data);
      end else begin
        check("m_data", 256'(m_data), 256'(exp_q.pop_front()));
        last_out = m_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [255:0] k, input logic kl, input logic enc, input logic [127:0] iv);
    int i0, d0;
    i0 = n_init;
    d0 = n_done;
    cfg_key = k; cfg_keylen = kl; cfg_enc_dec = enc; cfg_iv = iv; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    enc_m = enc;
    chain_m = iv;
    for (int i = 0; i < TMO && n_done == d0; i++) tick();
    check("core_init_pulses", 256'(n_init - i0), 256'(1));
    check("cfg_done_pulses", 256'(n_done - d0), 256'(1));
    check("key_valid", 256'(key_valid), 256'(1));
    check("core_key", core_key, k);
    check("core_keylen", 256'(core_keylen), 256'(kl));
    check("core_enc_dec", 256'(core_enc_dec), 256'(enc));
  endtask

  // Expected core input and stream output for plaintext/ciphertext d.
  task automatic model(input logic [127:0] d, output logic [127:0] cin, output logic [127:0] exp);
`ifdef AES_STREAM_CBC_EN
    if (enc_m) begin
      cin = d ^ chain_m;
      exp = core_fn(cfg_key, 1'b1, cin);
      chain_m = exp;
    end else begin
      cin = d;
      exp = core_fn(cfg_key, 1'b0, d) ^ chain_m;
      chain_m = d;
    end
`else
    cin = d;
    exp = core_fn(cfg_key, enc_m, d);
`endif
  endtask

  task automatic send(input logic [127:0] d, output logic [127:0] exp);
    logic [127:0] cin;
    bit ok;
    ok = 1'b0;
    model(d, cin, exp);
    s_data = d;
    s_valid = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    check("s_handshake", 256'(ok), 256'(1));
    if (!ok) begin s_valid = 1'b0; return; end
    exp_q.push_back(exp);
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    check("core_next_latency", 256'(core_next), 256'(1));
    check("core_block", 256'(core_block), 256'(cin));
  endtask

  task automatic drain();
    for (int i = 0; i < TMO && exp_q.size() != 0; i++) tick();
    check("drain", 256'(exp_q.size()), 256'(0));
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, 256'(s_ready), 256'(0));
    check({tag, "_m_valid"}, 256'(m_valid), 256'(0));
    check({tag, "_key_valid"}, 256'(key_valid), 256'(0));
    check({tag, "_cfg_done"}, 256'(cfg_done), 256'(0));
    check({tag, "_core_init"}, 256'(core_init), 256'(0));
    check({tag, "_core_next"}, 256'(core_next), 256'(0));
    check({tag, "_m_data"}, 256'(m_data), 256'(0));
    check({tag, "_core_block"}, 256'(core_block), 256'(0));
    check({tag, "_core_key"}, core_key, 256'(0));
    check({tag, "_core_cfg"}, 256'({core_keylen, core_enc_dec}), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    logic [127:0] ea, eb, ex;
    logic [255:0] key2;
    int nx, d0;
    bit seen_rdy, seen_mv;

    reset = 1'b0; cfg_key = '0; cfg_keylen = 1'b0; cfg_enc_dec = 1'b0; cfg_iv = '0;
    cfg_load = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Block offered before any key is never accepted.
    s_valid = 1'b1; s_data = 128'h1;
    seen_rdy = 1'b0;
    repeat (4) begin @(negedge clk); if (s_ready) seen_rdy = 1'b1; end
    check("idle_s_ready", 256'(seen_rdy), 256'(0));
    tick();
    s_valid = 1'b0;

    // AES-128 key load and FIPS-197 ECB vector.
    load_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0, 1'b1, 128'h0);
    nx = n_next;
    send(128'h00112233445566778899aabbccddeeff, ex);
    drain();
    check("ecb_next_count", 256'(n_next - nx), 256'(1));
    check("ecb_vector", 256'(last_out), 256'(128'h69c4e0d86e7a0430d8cdb78070b4c55a));
    send(128'h0, ex);
    drain();
    send(128'hdeadbeef_00000000_ffffffff_12345678, ex);
    drain();

    // Backpressure: result held while the next block waits.
    m_ready = 1'b0;
    send(128'ha5a5a5a5_5a5a5a5a_a5a5a5a5_5a5a5a5a, ea);
    seen_mv = 1'b0;
    for (int i = 0; i < TMO && !seen_mv; i++) begin @(negedge clk); seen_mv = m_valid; end
    check("bp_m_valid_rise", 256'(seen_mv), 256'(1));
    tick();
    s_data = 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f;
    s_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_m_valid", 256'(m_valid), 256'(1));
      check("bp_m_data", 256'(m_data), 256'(ea));
      check("bp_s_ready", 256'(s_ready), 256'(0));
    end
    tick();
    m_ready = 1'b1;
    send(128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f, eb);
    drain();

    // Reload and block offered together: reload wins, block waits for the new key.
    key2 = {128'h11111111_11111111_11111111_11111111, 128'h22222222_22222222_22222222_22222222};
    d0 = n_done;
    cfg_key = key2; cfg_keylen = 1'b1; cfg_enc_dec = 1'b1; cfg_iv = 128'h0; cfg_load = 1'b1;
    s_data = 128'h0123456789abcdef_fedcba9876543210; s_valid = 1'b1;
    @(negedge clk);
    check("collide_s_ready", 256'(s_ready), 256'(0));
    tick();
    cfg_load = 1'b0;
    enc_m = 1'b1;
    chain_m = 128'h0;
    send(128'h0123456789abcdef_fedcba9876543210, ex);
    check("collide_done_first", 256'(n_done - d0), 256'(1));
    check("collide_keylen", 256'(core_keylen), 256'(1));
    check("collide_core_key", core_key, key2);
    drain();

    // Reset while the core is working.
    send(128'h55555555_55555555_55555555_55555555, ex);
    tick();
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    s_valid = 1'b1; s_data = 128'h77;
    seen_rdy = 1'b0; seen_mv = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (s_ready) seen_rdy = 1'b1;
      if (m_valid) seen_mv = 1'b1;
    end
    check("post_reset_s_ready", 256'(seen_rdy), 256'(0));
    check("post_reset_m_valid", 256'(seen_mv), 256'(0));
    tick();
    s_valid = 1'b0;
    load_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0, 1'b1, 128'h0);
    send(128'h00112233445566778899aabbccddeeff, ex);
    drain();
    check("post_reset_vector", 256'(last_out), 256'(128'h69c4e0d86e7a0430d8cdb78070b4c55a));

`ifdef AES_STREAM_CBC_EN
    // SP 800-38A CBC-AES128 first block, both directions.
    load_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 1'b1,
             128'h000102030405060708090a0b0c0d0e0f);
    send(128'h6bc1bee22e409f96e93d7e117393172a, ex);
    drain();
    check("cbc_encrypt", 256'(last_out), 256'(128'h7649abac8119b246cee98e9b12e9197d));
    load_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 1'b0,
             128'h000102030405060708090a0b0c0d0e0f);
    send(128'h7649abac8119b246cee98e9b12e9197d, ex);
    drain();
    check("cbc_decrypt", 256'(last_out), 256'(128'h6bc1bee22e409f96e93d7e117393172a));
`endif

    repeat (5) tick();
    check("tail_queue_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 clk  in  1  single clock; all logic on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 cfg_key  in  256  key; a 128-bit key occupies [255:128].
REQ-004 cfg_keylen  in  1  0 = AES-128, 1 = AES-256.
REQ-005 cfg_enc_dec  in  1  1 = encrypt, 0 = decrypt.
REQ-006 cfg_iv  in  128  initial chaining value, used only when CBC is compiled in.
REQ-007 cfg_load  in  1  one-cycle key/config load request.
REQ-008 cfg_done  out  1  one-cycle pulse when key expansion completes.
REQ-009 key_valid  out  1  high while an expanded key is loaded.
REQ-010 s_valid / s_ready / s_data  in / out / in  1 / 1 / 128  input block stream.
REQ-011 m_valid / m_ready / m_data  out / in / out  1 / 1 / 128  result block stream.
REQ-012 core_init, core_next  out  1 each  one-cycle strobes to the AES core.
REQ-013 core_key, core_keylen, core_enc_dec  out  256/1/1  latched config driven to the core.
REQ-014 core_block  out  128  block to the core, held stable from START until OUT.
REQ-015 core_ready, core_result_valid, core_result  in  1/1/128  core status and result.

Function
REQ-016 States: IDLE, KEY_INIT, KEY_WAIT, RDY, START, WAIT, OUT.
REQ-017 IDLE and RDY: on cfg_load, latch cfg_key/keylen/enc_dec (and cfg_iv), clear key_valid, go to KEY_INIT; cfg_load is ignored in all other states.
REQ-018 KEY_INIT: core_init=1 for exactly one cycle -> KEY_WAIT.
REQ-019 KEY_WAIT: core_ready is ignored in the first cycle; on core_ready=1 in any later cycle, pulse cfg_done, set key_valid, go to RDY.
REQ-020 s_ready = (state==RDY) && !cfg_load; cfg_load has priority over a same-cycle s_valid.
REQ-021 Handshake (s_valid && s_ready): latch the block, go to START; core_block is valid from the START cycle onward.
REQ-022 START: core_next=1 for exactly one cycle -> WAIT.
REQ-023 WAIT: the first cycle is ignored; afterwards, on core_ready && core_result_valid, capture m_data -> OUT.
REQ-024 OUT: m_valid=1 with m_data stable until m_ready=1, then go to RDY; one block is in flight at a time.
REQ-025 Latency: core_next asserts 1 cycle after the s handshake; m_valid asserts 1 cycle after completion is sampled in WAIT.
REQ-026 core_enc_dec and core_keylen do not change between cfg_load events.
REQ-027 s_valid in any state other than RDY is not accepted; data is neither dropped nor duplicated.

Reset
REQ-028 Reset forces IDLE and clears key_valid.
REQ-029 Reset drives s_ready, m_valid, cfg_done, core_init and core_next to 0, and clears m_data, core_block and all latched config to 0.
REQ-030 Reset mid-operation aborts the operation with no m_valid and no cfg_done; a new cfg_load is required before any data is accepted.

Configuration
REQ-031 Macro AES_STREAM_CBC_EN compiled in:
  - chain register loaded from cfg_iv on cfg_load.
  - Encrypt: core_block = s_data XOR chain; chain <= core_result on capture.
  - Decrypt: m_data = core_result XOR chain; chain <= the accepted ciphertext on capture.
REQ-032 Macro absent (ECB):
  - no chain register; cfg_iv is ignored.
  - core_block = s_data and m_data = core_result.
  - The port list is identical in both builds.

Verification
REQ-033 Key load: cfg_load, key 000102030405060708090a0b0c0d0e0f, keylen=0, enc=1 -> one core_init pulse, then cfg_done pulse, key_valid=1.
REQ-034 ECB encrypt: s_data 00112233445566778899aabbccddeeff -> m_data 69c4e0d86e7a0430d8cdb78070b4c55a, exactly one core_next.
REQ-035 CBC encrypt (macro on):
  - key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102030405060708090a0b0c0d0e0f.
  - pt 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d.
  - CBC decrypt of that ciphertext returns the pt.
REQ-036 Backpressure: m_ready held 0 for 10 cycles -> m_valid and m_data stable, s_ready=0 throughout; release -> next block accepted.
REQ-037 Simultaneous cfg_load and s_valid in RDY -> s_ready=0, key reload proceeds, block accepted only after cfg_done.
REQ-038 Reset asserted in WAIT -> all outputs 0 next cycle, no m_valid after release, and s_ready=0 until a key is reloaded.
